// File: rtl/debounce_pkg.sv
// Shared constants and counter sizing for the pushbutton debouncer.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package debounce_pkg;

    localparam int CLK_HZ                = 50_000_000;
    localparam int DEFAULT_STABLE_CYCLES = CLK_HZ / 50;   // 20 ms
    localparam int DEFAULT_HOLD_CYCLES   = CLK_HZ;        // 1 s

    // Wide enough to hold the larger terminal value without wrapping.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int m;
        m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, stability counter, level, press/release/hold strobes.
// Latency: STABLE_CYCLES+2 edges from a settled input to level/strobe; hold HOLD_CYCLES edges after press.
// Backpressure: none; strobes are single-cycle and unconditional.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] S_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] scnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_in ^ ACTIVE_LOW_IN;
            sync2 <= sync1;
        end
    end

    // Any cycle of agreement with the current level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scnt          <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync2 == level) begin
                scnt <= '0;
            end else if (scnt == S_LAST) begin
                scnt          <= '0;
                level         <= sync2;
                press_pulse   <= sync2;
                release_pulse <= ~sync2;
            end else begin
                scnt <= scnt + CW'(1);
            end
        end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam logic [CW-1:0] H_MAX = CW'(HOLD_CYCLES);
        logic [CW-1:0] hcnt;

        // Saturating at H_MAX makes the strobe fire once per press.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                hcnt       <= '0;
                hold_pulse <= 1'b0;
            end else begin
                hold_pulse <= 1'b0;
                if (!level) begin
                    hcnt <= '0;
                end else if (hcnt != H_MAX) begin
                    hcnt       <= hcnt + CW'(1);
                    hold_pulse <= (hcnt == H_MAX - CW'(1));
                end
            end
        end
    end else begin : g_no_hold
        assign hold_pulse = 1'b0;
    end

endmodule

// File: rtl/button_debouncer.sv
// N-channel pushbutton conditioner: debounced level plus press, release and hold strobes.
// Latency: STABLE_CYCLES+2 clk edges from a settled pin change; all outputs registered.
// Backpressure: none; channels are independent and report simultaneously.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int N             = 4,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] buttons_in,
    output logic [N-1:0] buttons_out,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] hold_pulse
);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("button_debouncer: STABLE_CYCLES must be >= 1");
    end

    if (HOLD_CYCLES < 0) begin : g_bad_hold
        $error("button_debouncer: HOLD_CYCLES must be >= 0");
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .ACTIVE_LOW_IN (ACTIVE_LOW_IN)
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .button_in     (buttons_in[i]),
            .level         (buttons_out[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .hold_pulse    (hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (N=4, STABLE=4, HOLD=10).
// Two instances: active-low pins (main) and active-high pins (polarity).
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] buttons_in;
    logic [3:0] bo, pp, rp, hp;
    logic [3:0] pol_in;
    logic [3:0] p_bo, p_pp, p_rp, p_hp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .N(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW_IN(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .buttons_in(buttons_in),
        .buttons_out(bo), .press_pulse(pp), .release_pulse(rp), .hold_pulse(hp)
    );

    button_debouncer #(
        .N(4), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW_IN(1'b0)
    ) dut_p (
        .clk(clk), .reset_n(reset_n), .buttons_in(pol_in),
        .buttons_out(p_bo), .press_pulse(p_pp), .release_pulse(p_rp), .hold_pulse(p_hp)
    );

    typedef struct {
        logic [3:0] in;
        logic [3:0] out;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] hold;
        int         reps;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [3:0] o, input logic [3:0] p,
                           input logic [3:0] r, input logic [3:0] h,
                           input logic [3:0] eo, input logic [3:0] ep,
                           input logic [3:0] er, input logic [3:0] eh);
        chk({tag, ".out"}, o, eo);
        chk({tag, ".press"}, p, ep);
        chk({tag, ".release"}, r, er);
        chk({tag, ".hold"}, h, eh);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] in, input logic [3:0] out,
                                input logic [3:0] press, input logic [3:0] rel,
                                input logic [3:0] hold, input int reps);
        vec_t v;
        v.in = in; v.out = out; v.press = press; v.rel = rel; v.hold = hold; v.reps = reps;
        vecs.push_back(v);
    endfunction

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        buttons_in = 4'hF;
        pol_in     = 4'h0;

        // Clean press on ch0: press at edge 6, hold at 16, then release at 6th edge.
        add(4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(4'hE, 4'h1, 4'h1, 4'h0, 4'h0, 1);
        add(4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 9);
        add(4'hE, 4'h1, 4'h0, 4'h0, 4'h1, 1);
        add(4'hE, 4'h1, 4'h0, 4'h0, 4'h0, 4);
        add(4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 5);
        add(4'hF, 4'h0, 4'h0, 4'h1, 4'h0, 1);
        add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 3);
        // Short press on ch2: released before the hold threshold.
        add(4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(4'hB, 4'h4, 4'h4, 4'h0, 4'h0, 1);
        add(4'hB, 4'h4, 4'h0, 4'h0, 4'h0, 2);
        add(4'hF, 4'h4, 4'h0, 4'h0, 4'h0, 5);
        add(4'hF, 4'h0, 4'h0, 4'h4, 4'h0, 1);
        add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 6);
        // All four channels pressed and released together.
        add(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 5);
        add(4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1);
        add(4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 3);
        add(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 5);
        add(4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1);
        add(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 2);

        #23;
        chk_all("reset", bo, pp, rp, hp, 4'h0, 4'h0, 4'h0, 4'h0);
        chk_all("reset_pol", p_bo, p_pp, p_rp, p_hp, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            buttons_in = vecs[k].in;
            for (int r = 0; r < vecs[k].reps; r++) begin
                tick();
                chk_all($sformatf("vec%0d_%0d", k, r), bo, pp, rp, hp,
                        vecs[k].out, vecs[k].press, vecs[k].rel, vecs[k].hold);
            end
        end

        // Bounce on ch1: low 3, high 1, then low; accepted 6 edges after the last low settles.
        for (int e = 1; e <= 13; e++) begin
            buttons_in = (e == 4) ? 4'hF : 4'hD;
            tick();
            chk_all($sformatf("bounce_e%0d", e), bo, pp, rp, hp,
                    (e >= 10) ? 4'h2 : 4'h0, (e == 10) ? 4'h2 : 4'h0, 4'h0, 4'h0);
        end
        buttons_in = 4'hF;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk_all($sformatf("bounce_rel_e%0d", e), bo, pp, rp, hp,
                    (e < 6) ? 4'h2 : 4'h0, 4'h0, (e == 6) ? 4'h2 : 4'h0, 4'h0);
        end

        // Reset while ch3 is mid-count (scnt=2).
        buttons_in = 4'h7;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk_all($sformatf("mid_e%0d", e), bo, pp, rp, hp, 4'h0, 4'h0, 4'h0, 4'h0);
        end
        chk("mid_scnt_before_reset", 4'(dut.g_ch[3].u_chan.scnt), 4'h2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_scnt_after_reset", 4'(dut.g_ch[3].u_chan.scnt), 4'h0);
        chk("mid_sync2_after_reset", {3'b000, dut.g_ch[3].u_chan.sync2}, 4'h0);
        chk_all("mid_reset", bo, pp, rp, hp, 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("mid_reset_held", bo, pp, rp, hp, 4'h0, 4'h0, 4'h0, 4'h0);
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk_all($sformatf("post_rst_e%0d", e), bo, pp, rp, hp,
                    (e == 6) ? 4'h8 : 4'h0, (e == 6) ? 4'h8 : 4'h0, 4'h0, 4'h0);
        end
        buttons_in = 4'hF;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk_all($sformatf("post_rst_rel_e%0d", e), bo, pp, rp, hp,
                    (e < 6) ? 4'h8 : 4'h0, 4'h0, (e == 6) ? 4'h8 : 4'h0, 4'h0);
        end

        // Active-high pins: ch0 driven 0->1.
        pol_in = 4'h1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            chk_all($sformatf("pol_e%0d", e), p_bo, p_pp, p_rp, p_hp,
                    (e >= 6) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
